mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external data-memory read channel and one write channel among NUM_CONSUMERS LSUs (one per thread).
- Sits between the per-thread LSU memory ports and the global data memory.
- Grants one transaction at a time, round-robin. Relays address/data with a four-phase valid/ready handshake on both sides.

Parameters:
- NUM_CONSUMERS, 4, number of LSU requesters (2..8).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request; held until that LSU's ready is seen.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  read complete; held until the consumer drops valid.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data; valid while the matching ready is high.
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data.
- consumer_write_ready  out  NUM_CONSUMERS  write complete; held until the consumer drops valid.
- mem_read_valid  out  1  read request to memory.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  memory read done; data on mem_read_data in the same cycle.
- mem_read_data  in  DATA_BITS  memory read data.
- mem_write_valid  out  1  write request to memory.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  memory write accepted.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr = NUM_CONSUMERS-1, so consumer 0 has top priority first. Reset mid-transaction aborts immediately; a consumer still holding valid is re-served from IDLE.
- All outputs are registered.
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers rr_ptr+1, rr_ptr+2, … (mod NUM_CONSUMERS); the first with read_valid or write_valid wins.
  - If the winner has both valids, read wins.
  - Latch grant index g, address, and write data. Next cycle: mem_read_valid=1 (-> READ_WAITING) or mem_write_valid=1 (-> WRITE_WAITING).
  - No request: stay in IDLE.
- READ_WAITING: hold mem_read_valid/address stable until mem_read_ready=1. On that edge: mem_read_valid<=0, consumer_read_data[g]<=mem_read_data, consumer_read_ready[g]<=1, -> READ_RELAYING.
- WRITE_WAITING: same sequence with mem_write_valid/ready, ending with consumer_write_ready[g]<=1, -> WRITE_RELAYING.
- RELAYING: hold ready[g] and data until the consumer's valid[g]=0. Then ready[g]<=0, rr_ptr<=g, -> IDLE.
- Latency with a zero-wait memory (ready in the first cycle valid is seen): request edge to consumer ready is 3 cycles. Minimum spacing between grants is 4 cycles plus the consumer's valid-drop delay.
- Fairness: a consumer holding valid continuously is served within NUM_CONSUMERS grants.
- Outputs for consumers other than g stay 0.
- mem_read_valid and mem_write_valid are never high together.
- Memory stall: wait indefinitely in the WAITING state; no timeout.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds output port grant_count (16 bits). It increments by 1 on each RELAYING->IDLE transition, saturates at 0xFFFF, and clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg: state encoding constants (IDLE=0, READ_WAITING=1, WRITE_WAITING=2, READ_RELAYING=3, WRITE_RELAYING=4), the 3-bit state width, and the grant-index width ($clog2(NUM_CONSUMERS)).
- One sub-module, rr_picker: combinational round-robin priority select. Inputs: request vector, rr_ptr. Outputs: found, index.

Test Plan:
- Single read: consumer 1 read_valid, address 0x10; memory returns 0x55 with zero wait -> mem_read_address=0x10; consumer_read_data[1]=0x55 and consumer_read_ready[1]=1 three cycles after the request; ready drops one cycle after valid drops.
- Single write: consumer 2 writes 0xAA to 0x20 -> mem_write_address=0x20, mem_write_data=0xAA; consumer_write_ready[2] asserted; mem_read_valid stays 0 throughout.
- Round-robin: all 4 consumers issue reads (addresses 0x00–0x03) simultaneously after reset, each re-requesting immediately after completion -> grant order 0,1,2,3,0 with no starvation.
- Memory stall: mem_read_ready held 0 for 10 cycles -> mem_read_valid and address stable for all 10 cycles; no consumer ready until the memory completes.
- Reset mid-transaction: reset pulsed in READ_RELAYING -> all outputs 0 the next cycle; with consumer valid still high, the read is re-issued starting from consumer 0 priority.
- Read+write on same consumer: consumer 0 asserts both -> read served first, write on a later grant; with MEM_ARB_PERF_EN defined, grant_count=2 afterward.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : arbiter FSM state encoding (3 bits)
//   grant_bits  : width of a grant index for a given number of consumers
package mem_arb_pkg;

    localparam int unsigned STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } arb_state_t;

    function automatic int unsigned grant_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin priority select.
// Ports:
//   req    : request vector, one bit per consumer
//   rr_ptr : last granted index; search starts at rr_ptr+1
//   found  : at least one request is pending
//   index  : first requesting consumer after rr_ptr (mod NUM_CONSUMERS)
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned IDX_W         = grant_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [IDX_W-1:0]         rr_ptr,
    output logic                     found,
    output logic [IDX_W-1:0]         index
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_CONSUMERS; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_CONSUMERS;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read channel and one write
// channel among NUM_CONSUMERS LSUs, one transaction at a time, with a
// four-phase valid/ready handshake on both sides. All outputs registered.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   consumer_read_valid/address     : per-LSU read requests (packed)
//   consumer_read_ready/data        : per-LSU read completion (packed)
//   consumer_write_valid/address/data : per-LSU write requests (packed)
//   consumer_write_ready            : per-LSU write completion
//   mem_read_valid/address, mem_read_ready/data   : memory read channel
//   mem_write_valid/address/data, mem_write_ready : memory write channel
//   grant_count (MEM_ARB_PERF_EN only) : saturating count of completed grants
// Build option: define MEM_ARB_PERF_EN to add the grant_count output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]                          grant_count,
`endif
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int unsigned IDX_W = grant_bits(NUM_CONSUMERS);

    arb_state_t                         state_q, state_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                   grant_q, grant_d;
    logic                               pick_found;
    logic [IDX_W-1:0]                   pick_idx;

    logic [NUM_CONSUMERS-1:0]           rd_ready_d, wr_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_d;
    logic                               mrv_d, mwv_d;
    logic [ADDR_BITS-1:0]               mra_d, mwa_d;
    logic [DATA_BITS-1:0]               mwd_d;

    rr_picker #(
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .IDX_W        (IDX_W)
    ) u_picker (
        .req   (consumer_read_valid | consumer_write_valid),
        .rr_ptr(rr_ptr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= IDLE;
            rr_ptr_q             <= IDX_W'(NUM_CONSUMERS - 1);
            grant_q              <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            state_q              <= state_d;
            rr_ptr_q             <= rr_ptr_d;
            grant_q              <= grant_d;
            consumer_read_ready  <= rd_ready_d;
            consumer_read_data   <= rd_data_d;
            consumer_write_ready <= wr_ready_d;
            mem_read_valid       <= mrv_d;
            mem_read_address     <= mra_d;
            mem_write_valid      <= mwv_d;
            mem_write_address    <= mwa_d;
            mem_write_data       <= mwd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        rd_ready_d = consumer_read_ready;
        rd_data_d  = consumer_read_data;
        wr_ready_d = consumer_write_ready;
        mrv_d      = mem_read_valid;
        mra_d      = mem_read_address;
        mwv_d      = mem_write_valid;
        mwa_d      = mem_write_address;
        mwd_d      = mem_write_data;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    // A consumer with both requests pending is served read-first.
                    if (consumer_read_valid[pick_idx]) begin
                        mrv_d   = 1'b1;
                        mra_d   = consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                        state_d = READ_WAITING;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                        mwd_d   = consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
                        state_d = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mrv_d                                   = 1'b0;
                    rd_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
                    rd_ready_d[grant_q]                     = 1'b1;
                    state_d                                 = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mwv_d               = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    state_d             = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[grant_q]) begin
                    rd_ready_d[grant_q]                     = 1'b0;
                    rd_data_d[grant_q*DATA_BITS +: DATA_BITS] = '0;
                    rr_ptr_d                                = grant_q;
                    state_d                                 = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_q]) begin
                    wr_ready_d[grant_q] = 1'b0;
                    rr_ptr_d            = grant_q;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic release_grant;

    assign release_grant =
        (state_q == READ_RELAYING  && !consumer_read_valid[grant_q]) ||
        (state_q == WRITE_RELAYING && !consumer_write_valid[grant_q]);

    always_ff @(posedge clk) begin
        if (reset)
            grant_count <= '0;
        else if (release_grant && grant_count != 16'hFFFF)
            grant_count <= grant_count + 16'd1;
    end
`endif

endmodule
